// File: rtl/matrix_pkg.sv
// Shared parameters, clear-engine states and address mapping
// for the matrix bank slice.
package matrix_pkg;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_NUM_SLOTS = 4;
   localparam int DEF_MAX_DIM   = 5;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } clr_state_t;

   function automatic int lin_addr(
      input int slot,
      input int row,
      input int col,
      input int max_dim
   );
      return slot * max_dim * max_dim + row * max_dim + col;
   endfunction

endpackage

// File: rtl/matrix_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port and one
// synchronous read port; a same-address read returns old data.
module matrix_sdp_ram #(
   parameter int W     = 16,
   parameter int DEPTH = 100,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/matrix_bank.sv
// Matrix slot store: dim registers, bounds-checked arbitrated
// element writes, registered ALU reads and a slot-clear engine.
module matrix_bank
   import matrix_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int MAX_DIM   = DEF_MAX_DIM,
   parameter int SLOT_W    = $clog2(NUM_SLOTS),
   parameter int IDX_W     = $clog2(MAX_DIM + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SLOT_W-1:0]    user_slot_idx,
   input  logic [IDX_W-1:0]     user_row,
   input  logic [IDX_W-1:0]     user_col,
   input  logic [DATA_W-1:0]    user_data,
   input  logic                 user_we,
   input  logic [IDX_W-1:0]     user_dim_m,
   input  logic [IDX_W-1:0]     user_dim_n,
   input  logic                 user_dim_we,
   output logic                 user_stall,
   input  logic [SLOT_W-1:0]    alu_rd_slot,
   input  logic [IDX_W-1:0]     alu_rd_row,
   input  logic [IDX_W-1:0]     alu_rd_col,
   input  logic                 alu_rd_en,
   output logic [DATA_W-1:0]    alu_rd_data,
   output logic                 alu_rd_valid,
   output logic                 alu_rd_oob,
   output logic [IDX_W-1:0]     alu_current_m,
   output logic [IDX_W-1:0]     alu_current_n,
   input  logic [SLOT_W-1:0]    alu_wr_slot,
   input  logic [IDX_W-1:0]     alu_wr_row,
   input  logic [IDX_W-1:0]     alu_wr_col,
   input  logic [DATA_W-1:0]    alu_wr_data,
   input  logic                 alu_wr_we,
   input  logic [IDX_W-1:0]     alu_res_m,
   input  logic [IDX_W-1:0]     alu_res_n,
   input  logic                 alu_dim_we,
   output logic                 alu_wr_stall,
   input  logic [SLOT_W-1:0]    clr_slot,
   input  logic                 clr_req,
   output logic                 clr_busy,
   output logic                 clr_done,
   output logic [NUM_SLOTS-1:0] slot_valid,
   output logic                 wr_err
);

   localparam int MD2   = MAX_DIM * MAX_DIM;
   localparam int DEPTH = NUM_SLOTS * MD2;
   localparam int AW    = $clog2(DEPTH);
   localparam int KW    = $clog2(MD2);
   localparam logic [IDX_W-1:0] MAX_D  = IDX_W'(MAX_DIM);
   localparam logic [KW-1:0]    K_LAST = KW'(MD2 - 1);

   logic [IDX_W-1:0]     dim_m [NUM_SLOTS];
   logic [IDX_W-1:0]     dim_n [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] valid_q;

   clr_state_t           state, state_nx;
   logic [SLOT_W-1:0]    clr_slot_q;
   logic [KW-1:0]        clr_k;

   logic                 busy, sweep, done;
   logic                 user_ok, alu_ok, rd_ok;
   logic                 user_take, alu_take;
   logic                 user_dim_ok, alu_dim_ok, same_slot;
   logic                 err_nx, err_q;
   logic                 rd_valid_q, rd_oob_q;

   logic                 ram_we, ram_re;
   logic [AW-1:0]        ram_waddr, ram_raddr;
   logic [DATA_W-1:0]    ram_wdata, ram_rdata;

   function automatic logic dims_ok(
      input logic [IDX_W-1:0] m,
      input logic [IDX_W-1:0] n
   );
      return (m != '0) && (m <= MAX_D) && (n != '0) && (n <= MAX_D);
   endfunction

   assign busy  = (state != IDLE);
   assign sweep = (state == SWEEP);
   assign done  = (state == DONE);

   assign clr_busy   = busy;
   assign clr_done   = done;
   assign slot_valid = valid_q;
   assign wr_err     = err_q;

   assign alu_current_m = dim_m[alu_rd_slot];
   assign alu_current_n = dim_n[alu_rd_slot];

   assign user_ok = valid_q[user_slot_idx]
                 && (user_row < dim_m[user_slot_idx])
                 && (user_col < dim_n[user_slot_idx]);
   assign alu_ok  = valid_q[alu_wr_slot]
                 && (alu_wr_row < dim_m[alu_wr_slot])
                 && (alu_wr_col < dim_n[alu_wr_slot]);
   assign rd_ok   = valid_q[alu_rd_slot]
                 && (alu_rd_row < dim_m[alu_rd_slot])
                 && (alu_rd_col < dim_n[alu_rd_slot]);

   assign user_stall   = user_we & (busy | alu_wr_we);
   assign alu_wr_stall = alu_wr_we & busy;
   assign alu_take     = alu_wr_we & ~busy;
   assign user_take    = user_we & ~busy & ~alu_wr_we;

   assign user_dim_ok = dims_ok(user_dim_m, user_dim_n);
   assign alu_dim_ok  = dims_ok(alu_res_m, alu_res_n);
   assign same_slot   = alu_dim_we && (alu_wr_slot == user_slot_idx);

   assign err_nx = (alu_take & ~alu_ok)
                 | (user_take & ~user_ok)
                 | (alu_dim_we & ~alu_dim_ok)
                 | (user_dim_we & ~same_slot & ~user_dim_ok);

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      unique case (1'b1)
         sweep: begin
            ram_we    = 1'b1;
            ram_waddr = AW'(lin_addr(int'(clr_slot_q), 0,
                                     int'(clr_k), MAX_DIM));
         end
         alu_take: begin
            ram_we    = alu_ok;
            ram_waddr = AW'(lin_addr(int'(alu_wr_slot),
                                     int'(alu_wr_row),
                                     int'(alu_wr_col), MAX_DIM));
            ram_wdata = alu_wr_data;
         end
         user_take: begin
            ram_we    = user_ok;
            ram_waddr = AW'(lin_addr(int'(user_slot_idx),
                                     int'(user_row),
                                     int'(user_col), MAX_DIM));
            ram_wdata = user_data;
         end
         default: ;
      endcase
   end

   // Out-of-bounds reads never touch the array; the response is forced to 0.
   assign ram_re    = alu_rd_en & rd_ok;
   assign ram_raddr = AW'(lin_addr(int'(alu_rd_slot), int'(alu_rd_row),
                                   int'(alu_rd_col), MAX_DIM));

   matrix_sdp_ram #(
      .W     (DATA_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign alu_rd_data = (rd_valid_q && !rd_oob_q) ? ram_rdata : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_oob_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= alu_rd_en;
         rd_oob_q   <= alu_rd_en & ~rd_ok;
         err_q      <= err_nx;
      end
   end

   assign alu_rd_valid = rd_valid_q;
   assign alu_rd_oob   = rd_oob_q;

   // Clear completion outranks ALU, and ALU outranks user, per slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            dim_m[s] <= '0;
            dim_n[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (done && clr_slot_q == SLOT_W'(s)) begin
               dim_m[s]   <= '0;
               dim_n[s]   <= '0;
               valid_q[s] <= 1'b0;
            end else if (alu_dim_we && alu_dim_ok
                         && alu_wr_slot == SLOT_W'(s)) begin
               dim_m[s]   <= alu_res_m;
               dim_n[s]   <= alu_res_n;
               valid_q[s] <= 1'b1;
            end else if (user_dim_we && user_dim_ok && !same_slot
                         && user_slot_idx == SLOT_W'(s)) begin
               dim_m[s]   <= user_dim_m;
               dim_n[s]   <= user_dim_n;
               valid_q[s] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (clr_req) state_nx = SWEEP;
         SWEEP:   if (clr_k == K_LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_slot_q <= '0;
         clr_k      <= '0;
      end else if (state == IDLE && clr_req) begin
         clr_slot_q <= clr_slot;
         clr_k      <= '0;
      end else if (sweep) begin
         clr_k <= clr_k + 1'b1;
      end
   end

endmodule
